// File: rtl/icache_if.sv
// Fetch-side and line-fill bus of the instruction cache.
// ICACHE_STATS_EN adds the hit/miss counter outputs.
interface icache_if #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
);
  logic                    req_i;
  logic [ADDR_W-1:0]       pc_i;
  logic [31:0]             instr_o;
  logic                    ihit;
  logic                    mem_req_o;
  logic [ADDR_W-1:0]       mem_addr_o;
  logic                    mem_ack_i;
  logic [32*LINE_WORDS-1:0] mem_data_i;
`ifdef ICACHE_STATS_EN
  logic [31:0]             hit_cnt_o;
  logic [31:0]             miss_cnt_o;
`endif

  // master: fetch unit plus backing memory; slave: the cache itself
  modport master (
    output req_i, pc_i, mem_ack_i, mem_data_i,
    input  instr_o, ihit, mem_req_o, mem_addr_o
`ifdef ICACHE_STATS_EN
    , input hit_cnt_o, miss_cnt_o
`endif
  );

  modport slave (
    input  req_i, pc_i, mem_ack_i, mem_data_i,
    output instr_o, ihit, mem_req_o, mem_addr_o
`ifdef ICACHE_STATS_EN
    , output hit_cnt_o, miss_cnt_o
`endif
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with zero-cycle hits and whole-line refill.
// Define ICACHE_STATS_EN to add hit/miss counters.
module icache #(
  parameter int LINES      = 4,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input logic      clk,
  input logic      reset,
  icache_if.slave  bus
);
  localparam int OFF_W     = $clog2(LINE_WORDS);
  localparam int IDX_W     = $clog2(LINES);
  localparam int TAG_W     = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int LINE_BITS = 32 * LINE_WORDS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                 state;
  logic [LINES-1:0]       valid;
  logic [TAG_W-1:0]       tag_mem  [LINES];
  logic [LINE_BITS-1:0]   data_mem [LINES];
  logic                   mem_req_q;
  logic [ADDR_W-1:0]      miss_addr;

  logic [OFF_W-1:0]       pc_off;
  logic [IDX_W-1:0]       pc_idx;
  logic [TAG_W-1:0]       pc_tag;
  logic [IDX_W-1:0]       fill_idx;
  logic [TAG_W-1:0]       fill_tag;
  logic                   hit;
  logic                   unused_byte_bits;

  assign pc_off   = bus.pc_i[2 +: OFF_W];
  assign pc_idx   = bus.pc_i[2+OFF_W +: IDX_W];
  assign pc_tag   = bus.pc_i[ADDR_W-1 -: TAG_W];
  assign fill_idx = miss_addr[2+OFF_W +: IDX_W];
  assign fill_tag = miss_addr[ADDR_W-1 -: TAG_W];
  assign unused_byte_bits = ^bus.pc_i[1:0];

  // Gating with reset keeps ihit low while reset is asserted, even over stale valid bits
  assign hit = reset & (state == IDLE) & bus.req_i & valid[pc_idx] & (tag_mem[pc_idx] == pc_tag);

  assign bus.ihit       = hit;
  assign bus.instr_o    = hit ? data_mem[pc_idx][{pc_off, 5'b0} +: 32] : 32'h0;
  assign bus.mem_req_o  = mem_req_q;
  assign bus.mem_addr_o = miss_addr;

  // Control FSM: a miss latches the line-aligned pc, the fill ack marks the line valid
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      valid     <= '0;
      mem_req_q <= 1'b0;
      miss_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_i && !hit) begin
            miss_addr <= {bus.pc_i[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
            mem_req_q <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          if (bus.mem_ack_i) begin
            valid[fill_idx] <= 1'b1;
            mem_req_q       <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; a fill coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (reset && state == FILL && bus.mem_ack_i) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus.mem_data_i;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  // Observation-only counters, wrapping naturally at 2^32
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit)
        hit_cnt <= hit_cnt + 32'd1;
      if (state == IDLE && bus.req_i && !hit)
        miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign bus.hit_cnt_o  = hit_cnt;
  assign bus.miss_cnt_o = miss_cnt;
`endif
endmodule
